mips_hazard_ctrl: RTL and testbench
===================================

# mips_hazard_ctrl

Pipeline hazard and flush controller for the five-stage MIPS core. It generates the enable and clear signals for the F/D, D/E and E/M pipeline registers. It owns the multiply/divide busy counter that serialises HI/LO access. It also converts a CP0 exception request into a full younger-stage flush. It sits beside the decode stage: it reads register-use tags from D, producer tags from E and M, and the MDU start pulse from E.

## Interface
Parameters:
- MULT_CYC, 5, busy-count length loaded for mult/multu
- DIV_CYC, 10, busy-count length loaded for div/divu

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears the busy counter
- rs_D, rt_D  in  5 each  source register numbers of the instruction in D
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until the operand is consumed (0..2); 3 = operand unused
- A3E, A3M  in  5 each  destination register numbers in E and M
- RegWriteE, RegWriteM  in  1 each  producer writes the GPR file
- tnew_E, tnew_M  in  2 each  cycles until the producer result is forwardable
- md_D  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- startE  in  1  mult/div in E this cycle (one-cycle pulse)
- divE  in  1  qualifies startE: 1 = div/divu, 0 = mult/multu
- exc_req  in  1  CP0 takes an exception or interrupt at M this cycle
- en_F  out  1  PC enable
- en_D  out  1  F/D register enable
- clr_D, clr_E, clr_M  out  1 each  synchronous clear of the F/D, D/E and E/M registers
- busy  out  1  MDU occupied
- stall  out  1  D-stage stall, for debug and performance counting

## Operation
- Data hazard on rs:
  - E-stage term: RegWriteE && A3E==rs_D && rs_D!=0 && tuse_rs_D!=3 && tnew_E>tuse_rs_D.
  - M-stage term: the same with A3M, RegWriteM and tnew_M.
- Data hazard on rt: identical structure, using rt_D and tuse_rt_D.
- MDU state:
  - 4-bit down-counter cnt.
  - When startE=1 && exc_req=0 && cnt==0, load cnt with DIV_CYC if divE=1, else MULT_CYC.
  - Otherwise, if cnt!=0, decrement by 1.
  - busy = (cnt!=0) | (startE & ~exc_req).
- MDU hazard: md_D && busy.
- stall = data hazard | MDU hazard.
- Normal operation: en_F = en_D = ~stall; clr_E = stall (inserts a bubble); clr_D = clr_M = 0.
- Flush (exc_req=1) overrides stall:
  - en_F = en_D = 1, so the PC loads the handler address.
  - clr_D = clr_E = clr_M = 1.
  - stall output still reports the hazard value.
- An MDU operation already counting when exc_req arrives continues to completion; the instruction has committed.
- startE and exc_req in the same cycle: the start is discarded, cnt is not loaded and busy does not assert.
- startE while cnt!=0 cannot occur, because the MDU stall holds the mult/div in D. If it does occur, it is ignored (cnt continues) and the bench flags it as an error.
- Registers with rs/rt = 0, or with tuse = 3, never stall.

## Timing
- All outputs except cnt are combinational from the current inputs and cnt. There is zero-cycle latency from hazard detection to en/clr.
- Reset (asynchronous):
  - cnt = 0 immediately, so busy = 0.
  - With idle inputs, the outputs are en_F = en_D = 1, clr_* = 0, stall = 0.
  - Reset mid-count aborts the count; busy drops in the same cycle.
- MDU timing: startE in cycle t loads cnt = N at the edge ending t, where N is MULT_CYC or DIV_CYC. busy is high in cycles t..t+N (N+1 cycles) and low in cycle t+N+1.
- A stall lasts exactly while the condition holds. Because the producer advances, a Tnew-based stall resolves within at most 2 cycles.
- Counter width: 4 bits. Parameters are 1..15; loading uses the parameter value truncated to 4 bits.

## Test plan
- lw $1 in E (tnew_E=2) with addu $2,$1,$3 in D (tuse_rs_D=1):
  - 1 cycle of stall: en_D=0, clr_E=1.
  - Next cycle tnew_M=1 > 1 is false, so no stall.
- rs_D=0 with A3E=0, RegWriteE=1, tnew_E=2, tuse=0: stall=0 throughout.
- mult (startE=1, divE=0) followed by mflo in D: busy high for 6 cycles, stall for those 6 cycles, then en_D=1. Repeat with div: 11 cycles.
- exc_req=1 while a data stall is active: en_F=en_D=1, clr_D=clr_E=clr_M=1 in the same cycle.
- startE=1 and exc_req=1 together: busy=0 and cnt stays 0. Separately, exc_req at cnt=3: the count continues 3→2→1→0.
- Assert reset asynchronously at cnt=7 between edges: busy=0 before the next edge. After release, a new mult runs its full 6-cycle busy window.

Source files
------------

// File: rtl/mips_hazard_ctrl.sv
// Hazard/flush controller for the five-stage MIPS pipeline.
// Owns the MDU busy counter that serialises HI/LO access.
module mips_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] A3E,
  input  logic [4:0] A3M,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic [1:0] tnew_E,
  input  logic [1:0] tnew_M,
  input  logic       md_D,
  input  logic       startE,
  input  logic       divE,
  input  logic       exc_req,
  output logic       en_F,
  output logic       en_D,
  output logic       clr_D,
  output logic       clr_E,
  output logic       clr_M,
  output logic       busy,
  output logic       stall
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYC);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

  logic [3:0] cnt;
  logic       cnt_nz;
  logic       start_ok;
  logic       haz_rs;
  logic       haz_rt;
  logic       haz_md;

  assign cnt_nz   = (cnt != 4'd0);
  // A start coinciding with an exception is squashed with its instruction
  assign start_ok = startE & ~exc_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (start_ok && !cnt_nz) begin
      cnt <= divE ? DIV_N : MULT_N;
    end else if (cnt_nz) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    if (rs_D != 5'd0 && tuse_rs_D != 2'd3) begin
      haz_rs = (RegWriteE && A3E == rs_D && tnew_E > tuse_rs_D) ||
               (RegWriteM && A3M == rs_D && tnew_M > tuse_rs_D);
    end
    if (rt_D != 5'd0 && tuse_rt_D != 2'd3) begin
      haz_rt = (RegWriteE && A3E == rt_D && tnew_E > tuse_rt_D) ||
               (RegWriteM && A3M == rt_D && tnew_M > tuse_rt_D);
    end
  end

  always_comb begin
    busy   = cnt_nz | start_ok;
    haz_md = md_D & busy;
    stall  = haz_rs | haz_rt | haz_md;
    en_F   = ~stall;
    en_D   = ~stall;
    clr_D  = 1'b0;
    clr_E  = stall;
    clr_M  = 1'b0;
    // Flush wins: PC must load the handler and younger stages die
    if (exc_req) begin
      en_F  = 1'b1;
      en_D  = 1'b1;
      clr_D = 1'b1;
      clr_E = 1'b1;
      clr_M = 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl.
// Cycle-level model compared every negedge plus directed literals.
module tb_mips_hazard_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs_D, rt_D, A3E, A3M;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic       RegWriteE, RegWriteM, md_D, startE, divE, exc_req;
  logic       en_F, en_D, clr_D, clr_E, clr_M, busy, stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_end = -1;
  int n;

  mips_hazard_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .A3E(A3E), .A3M(A3M),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .tnew_E(tnew_E), .tnew_M(tnew_M),
    .md_D(md_D), .startE(startE), .divE(divE), .exc_req(exc_req),
    .en_F(en_F), .en_D(en_D),
    .clr_D(clr_D), .clr_E(clr_E), .clr_M(clr_M),
    .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic bit dep(input logic [4:0] r, input logic [1:0] tu,
                             input logic [4:0] a3, input logic we,
                             input logic [1:0] tn);
    return we && a3 == r && r != 0 && tu != 3 && int'(tn) > int'(tu);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Busy window model: cycles up to busy_end are busy
  always @(posedge reset) busy_end = cyc - 1;

  always @(posedge clk) begin
    if (reset) begin
      busy_end = cyc;
    end else if (startE && !exc_req) begin
      if (cyc <= busy_end) begin
        errors++;
        $display("FAIL illegal_start: start at busy cycle %0d", cyc);
      end else begin
        busy_end = cyc + (divE ? DC : MC);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit dh, bx, sx;
    dh = dep(rs_D, tuse_rs_D, A3E, RegWriteE, tnew_E) ||
         dep(rs_D, tuse_rs_D, A3M, RegWriteM, tnew_M) ||
         dep(rt_D, tuse_rt_D, A3E, RegWriteE, tnew_E) ||
         dep(rt_D, tuse_rt_D, A3M, RegWriteM, tnew_M);
    bx = (cyc <= busy_end) || (startE && !exc_req);
    sx = dh || (md_D && bx);
    chk("m_busy", int'(busy), int'(bx));
    chk("m_stall", int'(stall), int'(sx));
    chk("m_en_F", int'(en_F), int'(exc_req || !sx));
    chk("m_en_D", int'(en_D), int'(exc_req || !sx));
    chk("m_clr_D", int'(clr_D), int'(exc_req));
    chk("m_clr_E", int'(clr_E), int'(exc_req || sx));
    chk("m_clr_M", int'(clr_M), int'(exc_req));
  end

  task automatic idle();
    rs_D = 0; rt_D = 0; A3E = 0; A3M = 0;
    tuse_rs_D = 3; tuse_rt_D = 3; tnew_E = 0; tnew_M = 0;
    RegWriteE = 0; RegWriteM = 0;
    md_D = 0; startE = 0; divE = 0; exc_req = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_window(input logic dv, output int len);
    startE = 1; divE = dv; md_D = 1;
    len = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (stall) len++;
      next();
      startE = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    next();
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_en_F", int'(en_F), 1);
    chk("rst_stall", int'(stall), 0);
    chk("rst_clr_E", int'(clr_E), 0);
    next();
    reset = 0;

    // lw $1 in E, addu using $1 in D
    next();
    RegWriteE = 1; A3E = 1; tnew_E = 2;
    rs_D = 1; tuse_rs_D = 1; rt_D = 3; tuse_rt_D = 1;
    @(negedge clk);
    chk("lw_en_D", int'(en_D), 0);
    chk("lw_clr_E", int'(clr_E), 1);
    next();
    RegWriteE = 0; A3E = 0; tnew_E = 0;
    RegWriteM = 1; A3M = 1; tnew_M = 1;
    @(negedge clk);
    chk("lw_resolved", int'(stall), 0);

    // $0 never stalls
    next(); idle();
    rs_D = 0; A3E = 0; RegWriteE = 1; tnew_E = 2; tuse_rs_D = 0;
    @(negedge clk);
    chk("zero_reg", int'(stall), 0);
    next();
    @(negedge clk);
    chk("zero_reg2", int'(stall), 0);

    // unused operand, then an M-stage rt hazard
    next(); idle();
    rs_D = 4; A3E = 4; RegWriteE = 1; tnew_E = 2; tuse_rs_D = 3;
    @(negedge clk);
    chk("tuse3", int'(stall), 0);
    next(); idle();
    rt_D = 5; A3M = 5; RegWriteM = 1; tnew_M = 1; tuse_rt_D = 0;
    @(negedge clk);
    chk("rt_m_haz", int'(stall), 1);

    // exception over a data stall
    next(); idle();
    RegWriteE = 1; A3E = 1; tnew_E = 2; rs_D = 1; tuse_rs_D = 1;
    exc_req = 1;
    @(negedge clk);
    chk("exc_en_F", int'(en_F), 1);
    chk("exc_en_D", int'(en_D), 1);
    chk("exc_clr", int'({clr_D, clr_E, clr_M}), 7);
    chk("exc_stall", int'(stall), 1);

    // mult then mflo, and div then mflo
    next(); idle();
    busy_window(1'b0, n);
    chk("mult_len", n, MC + 1);
    chk("mult_en_D_after", int'(en_D), 1);
    next(); idle();
    busy_window(1'b1, n);
    chk("div_len", n, DC + 1);

    // start squashed by exception
    next(); idle();
    startE = 1; exc_req = 1;
    @(negedge clk);
    chk("squash_busy", int'(busy), 0);
    next(); idle();
    @(negedge clk);
    chk("squash_cnt0", int'(busy), 0);

    // exception at cnt=3: count still drains 3,2,1
    next();
    startE = 1;
    repeat (3) begin next(); startE = 0; end
    exc_req = 1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      next();
      exc_req = 0;
    end
    chk("exc_drain", n, 3);

    // async reset at cnt=7
    next(); idle();
    startE = 1; divE = 1;
    repeat (4) begin next(); startE = 0; end
    #6;
    chk("pre_rst_busy", int'(busy), 1);
    reset = 1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    next();
    reset = 0;
    next();
    busy_window(1'b0, n);
    chk("post_rst_mult", n, MC + 1);

    next(); idle();
    next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
